sdram128_line_reader: RTL and testbench

Burst-read initiator on the core side of the 128-bit SDRAM request interface; it complements the blocks that write through `sdram_write`/`sdram_din`. Given a start address and a length, it issues burst reads to the SDRAM controller, buffers the returned 128-bit words in a FIFO, and serialises them as a 16-bit pixel stream. It sits in `core` between the SDRAM request port and the VGA/GPU display path, sharing the `m_clock` domain with the request port.

---
 rtl/sdram128_line_reader_pkg.sv | 26 ++
 rtl/sdram128_line_reader_if.sv | 25 ++
 rtl/sdram128_line_reader_fifo.sv | 53 +++++
 rtl/sdram128_line_reader.sv | 187 ++++++++++++++++++
 tb/tb_sdram128_line_reader.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram128_line_reader_pkg.sv
// Shared encodings and widths for the SDRAM 128-bit line reader.
// Included by the FIFO, the bus interface and the top level.
package sdram128_line_reader_pkg;

    localparam int ADRS_W  = 25;
    localparam int DATA_W  = 128;
    localparam int PIX_W   = 16;
    localparam int LEN_W   = 12;
    localparam int BURST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_t;

    function automatic logic [BURST_W-1:0] min_burst(input logic [LEN_W-1:0] remain,
                                                     input int unsigned     max_burst);
        if (32'(remain) < max_burst)
            return remain[BURST_W-1:0];
        else
            return BURST_W'(max_burst);
    endfunction

endpackage

// File: rtl/sdram128_line_reader_if.sv
// SDRAM read-request bus and 16-bit pixel stream of the line reader.
// master = line reader side, slave = SDRAM controller / pixel consumer side.
interface sdram128_line_reader_if;
    import sdram128_line_reader_pkg::*;

    logic               sdram_read;
    logic [ADRS_W-1:0]  sdram_adrs;
    logic [BURST_W-1:0] sdram_burst;
    logic [DATA_W-1:0]  sdram_dout;
    logic               sdram_ack_100;
    logic               pix_valid;
    logic [PIX_W-1:0]   pix_data;
    logic               pix_ready;

    modport master (
        output sdram_read, sdram_adrs, sdram_burst, pix_valid, pix_data,
        input  sdram_dout, sdram_ack_100, pix_ready
    );

    modport slave (
        input  sdram_read, sdram_adrs, sdram_burst, pix_valid, pix_data,
        output sdram_dout, sdram_ack_100, pix_ready
    );

endinterface

// File: rtl/sdram128_line_reader_fifo.sv
// sync_fifo128: single-clock FIFO of 128-bit words with combinational head
// read, wrap-bit pointers and a free-entry count.
module sync_fifo128
    import sdram128_line_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_din,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_dout,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_free
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_count;
    logic              w_wr_en;
    logic              w_rd_en;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_free  = (AW+1)'(FIFO_DEPTH) - w_count;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // a pop frees the slot in the same cycle, so push+pop is fine even when full
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sdram128_line_reader.sv
// Burst-read initiator: fetches start_len 128-bit words from SDRAM and streams them
// as 16-bit pixels. Optional starvation counter: SDRAM_LINE_READER_UNDERRUN_EN.
//   state    | meaning
//   IDLE     | waiting for start
//   REQ      | burst pending; sdram_read raised once FIFO has room for the burst
//   DATA     | collecting remaining beats of the current burst
//   DRAIN    | all words fetched; waiting for the last pixel to be taken
module sdram128_line_reader
    import sdram128_line_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int BURST      = 4
) (
    input  logic                  i_m_clock,
    input  logic                  i_p_reset,
    input  logic                  i_start,
    input  logic [ADRS_W-1:0]     i_start_adrs,
    input  logic [LEN_W-1:0]      i_start_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_underrun,
    sdram128_line_reader_if.master io_bus
);
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_t          r_state, w_next_state;
    logic [ADRS_W-1:0]  r_adrs;
    logic [LEN_W-1:0]   r_remain;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_beats_left;
    logic               r_read;
    logic               r_done;
    logic [DATA_W-1:0]  r_shift;
    logic [2:0]         r_pix_cnt;
    logic               r_pix_valid;

    logic               w_load, w_push, w_pop, w_done_set, w_last_beat;
    logic               w_fifo_full, w_fifo_empty, w_space_ok, w_drained;
    logic               w_pix_fire, w_last_pix;
    logic [FREE_W-1:0]  w_free;
    logic [DATA_W-1:0]  w_head;
    logic [LEN_W-1:0]   w_remain_next;

    sync_fifo128 #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_m_clock),
        .i_rst   (i_p_reset),
        .i_push  (w_push),
        .i_din   (io_bus.sdram_dout),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_free  (w_free)
    );

    assign w_remain_next = r_remain - LEN_W'(r_burst);
    assign w_space_ok    = (32'(w_free) >= 32'(r_burst));
    assign w_last_beat   = w_push && (r_beats_left == 4'd1);
    assign w_pix_fire    = r_pix_valid && io_bus.pix_ready;
    assign w_last_pix    = w_pix_fire && (r_pix_cnt == 3'd7);
    assign w_pop         = !w_fifo_empty && (!r_pix_valid || w_last_pix);
    assign w_drained     = w_fifo_empty && (!r_pix_valid || w_last_pix);

    always_ff @(posedge i_m_clock) begin
        if (i_p_reset) r_state <= ST_IDLE;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_push       = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_start_len != '0) begin
                        w_load       = 1'b1;
                        w_next_state = ST_REQ;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            ST_REQ, ST_DATA: begin
                // an ack seen in REQ is already the first beat of the burst
                w_push = io_bus.sdram_ack_100 && (r_read || (r_state == ST_DATA));
                if (w_push) begin
                    if (r_beats_left == 4'd1)
                        w_next_state = (w_remain_next == '0) ? ST_DRAIN : ST_REQ;
                    else
                        w_next_state = ST_DATA;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_next_state = ST_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_m_clock) begin
        if (i_p_reset) begin
            r_adrs       <= '0;
            r_remain     <= '0;
            r_burst      <= '0;
            r_beats_left <= '0;
            r_read       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_load) begin
                r_adrs       <= i_start_adrs & ~ADRS_W'(7);
                r_remain     <= i_start_len;
                r_burst      <= min_burst(i_start_len, BURST);
                r_beats_left <= min_burst(i_start_len, BURST);
                r_read       <= 1'b1;
            end else begin
                if (w_push && r_read)
                    r_read <= 1'b0;
                else if ((r_state == ST_REQ) && !r_read && w_space_ok)
                    r_read <= 1'b1;
                if (w_push)
                    r_beats_left <= r_beats_left - 4'd1;
                if (w_last_beat) begin
                    r_adrs   <= r_adrs + ADRS_W'({r_burst, 3'b000});
                    r_remain <= w_remain_next;
                    if (w_remain_next != '0) begin
                        r_burst      <= min_burst(w_remain_next, BURST);
                        r_beats_left <= min_burst(w_remain_next, BURST);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_m_clock) begin
        if (i_p_reset) begin
            r_shift     <= '0;
            r_pix_cnt   <= '0;
            r_pix_valid <= 1'b0;
        end else if (w_pop) begin
            r_shift     <= w_head;
            r_pix_cnt   <= '0;
            r_pix_valid <= 1'b1;
        end else if (w_pix_fire) begin
            if (r_pix_cnt == 3'd7) begin
                r_pix_valid <= 1'b0;
            end else begin
                r_shift   <= r_shift >> PIX_W;
                r_pix_cnt <= r_pix_cnt + 3'd1;
            end
        end
    end

`ifdef SDRAM_LINE_READER_UNDERRUN_EN
    logic [15:0] r_underrun;

    always_ff @(posedge i_m_clock) begin
        if (i_p_reset)
            r_underrun <= '0;
        else if ((r_state == ST_IDLE) && i_start)
            r_underrun <= '0;
        else if (o_busy && io_bus.pix_ready && !r_pix_valid && (r_underrun != 16'hFFFF))
            r_underrun <= r_underrun + 16'd1;
    end

    assign o_underrun = r_underrun;
`else
    assign o_underrun = '0;
`endif

    a_no_overflow: assert property (@(posedge i_m_clock) disable iff (i_p_reset)
                                    !(w_push && w_fifo_full));

    assign o_busy             = (r_state != ST_IDLE);
    assign o_done             = r_done;
    assign io_bus.sdram_read  = r_read;
    assign io_bus.sdram_adrs  = r_adrs;
    assign io_bus.sdram_burst = r_burst;
    assign io_bus.pix_valid   = r_pix_valid;
    assign io_bus.pix_data    = r_shift[PIX_W-1:0];

endmodule

// File: tb/tb_sdram128_line_reader.sv
// Scoreboard bench for sdram128_line_reader: SDRAM responder model, random
// pixel backpressure, and a monitor checking requests, pixels and done.
module tb_sdram128_line_reader;
    localparam int FIFO_DEPTH = 16;
    localparam int BURST      = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [24:0] start_adrs;
    logic [11:0] start_len;
    logic        busy;
    logic        done;
    logic [15:0] underrun;

    sdram128_line_reader_if bus ();

    sdram128_line_reader #(.FIFO_DEPTH(FIFO_DEPTH), .BURST(BURST)) dut (
        .i_m_clock    (clk),
        .i_p_reset    (rst),
        .i_start      (start),
        .i_start_adrs (start_adrs),
        .i_start_len  (start_len),
        .o_busy       (busy),
        .o_done       (done),
        .o_underrun   (underrun),
        .io_bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [28:0] exp_req  [$];
    logic [15:0] exp_pix  [$];
    bit          exp_done [$];

    int ready_mode = 1;
    int ack_delay  = 0;
    bit abort      = 1'b0;
    int late_req   = 0;
    int done_cnt   = 0;
    int starve_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] pix_of(input logic [24:0] a);
        return a[15:0] ^ {a[24:16], a[6:0]} ^ 16'h5A3C;
    endfunction

    function automatic logic [127:0] word_of(input logic [24:0] a);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[16*k +: 16] = pix_of(a + 25'(k));
        return w;
    endfunction

    // reference: split into bursts of at most BURST words, 8 halfwords per word, wrap mod 2^25
    task automatic push_expect(input logic [24:0] a_in, input int len);
        logic [24:0] a;
        int rem;
        int b;
        a   = a_in & ~25'h7;
        rem = len;
        while (rem > 0) begin
            b = (rem < BURST) ? rem : BURST;
            exp_req.push_back({a, 4'(b)});
            a   = a + 25'(8 * b);
            rem = rem - b;
        end
        a = a_in & ~25'h7;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 8; k++) exp_pix.push_back(pix_of(a + 25'(k)));
            a = a + 25'd8;
        end
        exp_done.push_back(len == 0);
    endtask

    // SDRAM responder
    initial begin : sdram_model
        logic [24:0] a;
        int n;
        int late_served;
        late_served       = 0;
        bus.sdram_ack_100 = 1'b0;
        bus.sdram_dout    = '0;
        forever begin
            @(posedge clk); #1;
            if (late_req != late_served) begin
                late_served++;
                bus.sdram_ack_100 = 1'b1;
                bus.sdram_dout    = {4{32'hDEADBEEF}};
                @(posedge clk); #1;
                bus.sdram_ack_100 = 1'b0;
            end else if (bus.sdram_read && !rst && !abort) begin
                a = bus.sdram_adrs;
                n = int'(bus.sdram_burst);
                for (int b = 0; b < n; b++) begin
                    for (int d = 0; d < ack_delay && !abort; d++) begin
                        @(posedge clk); #1;
                    end
                    if (abort) break;
                    bus.sdram_ack_100 = 1'b1;
                    bus.sdram_dout    = word_of(a + 25'(8 * b));
                    @(posedge clk); #1;
                    bus.sdram_ack_100 = 1'b0;
                end
            end
        end
    end

    initial begin : ready_drv
        bus.pix_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.pix_ready = 1'b0;
                1:       bus.pix_ready = 1'b1;
                default: bus.pix_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    initial begin : monitor
        int cyc, acks_seen, hs_seen, occ, last_hs_cyc;
        bit prev_read, hold_valid, tag;
        logic [15:0] hold_data, px;
        logic [28:0] e;
        cyc = 0; acks_seen = 0; hs_seen = 0; last_hs_cyc = 0;
        prev_read = 1'b0; hold_valid = 1'b0; hold_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                acks_seen = 0; hs_seen = 0; prev_read = 1'b0; hold_valid = 1'b0;
            end else begin
                if (bus.sdram_read && !prev_read) begin
                    occ = acks_seen - hs_seen / 8 - (bus.pix_valid ? 1 : 0);
                    check("req_space", 32'((FIFO_DEPTH - occ) >= int'(bus.sdram_burst)), 32'd1);
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected actual=%0h required=none", bus.sdram_adrs);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_adrs", 32'(bus.sdram_adrs), 32'(e[28:4]));
                        check("req_burst", 32'(bus.sdram_burst), 32'(e[3:0]));
                    end
                end
                if (hold_valid)
                    check("pix_hold", {15'd0, bus.pix_valid, bus.pix_data}, {15'd0, 1'b1, hold_data});
                if (bus.pix_valid && bus.pix_ready) begin
                    hs_seen++;
                    if (exp_pix.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pix_unexpected actual=%0h required=none", bus.pix_data);
                    end else begin
                        px = exp_pix.pop_front();
                        check("pix_data", 32'(bus.pix_data), 32'(px));
                        if (exp_pix.size() == 0) last_hs_cyc = cyc;
                    end
                end
                hold_valid = bus.pix_valid && !bus.pix_ready;
                hold_data  = bus.pix_data;
                if (done) begin
                    if (exp_done.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected actual=1 required=0");
                    end else begin
                        tag = exp_done.pop_front();
                        if (!tag) check("done_timing", 32'(cyc), 32'(last_hs_cyc + 1));
                    end
                    done_cnt++;
                end
                if (start && !busy) starve_cnt = 0;
                else if (busy && bus.pix_ready && !bus.pix_valid) starve_cnt++;
                if (bus.sdram_ack_100 && busy) acks_seen++;
                prev_read = bus.sdram_read;
            end
        end
    end

    task automatic issue(input logic [24:0] a, input int len);
        push_expect(a, len);
        @(posedge clk); #1;
        start = 1'b1; start_adrs = a; start_len = 12'(len);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        if (len != 0) begin
            check("start_to_req", 32'(bus.sdram_read), 32'd1);
        end else begin
            check("zero_done", 32'(done), 32'd1);
            check("zero_no_read", 32'(bus.sdram_read), 32'd0);
        end
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(done_cnt != d0), 32'd1);
        check("req_left", 32'(exp_req.size()), 32'd0);
        check("pix_left", 32'(exp_pix.size()), 32'd0);
    endtask

    task automatic run(input logic [24:0] a, input int len);
        int d0;
        d0 = done_cnt;
        issue(a, len);
        wait_done(d0);
    endtask

    initial begin : main
        int n, t, bad;
        logic [15:0] exp_under;
        rst = 1'b1; start = 1'b0; start_adrs = '0; start_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_read", 32'(bus.sdram_read), 32'd0);
        check("rst_adrs", 32'(bus.sdram_adrs), 32'd0);
        check("rst_burst", 32'(bus.sdram_burst), 32'd0);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        ready_mode = 1; ack_delay = 0;
        run(25'h0000100, 4);
        run(25'h0000000, 10);

        // stall the consumer long enough to fill the FIFO, then release randomly
        ready_mode = 0;
        n = done_cnt;
        issue(25'h0123450, 40);
        repeat (200) @(negedge clk);
        check("stall_read_low", 32'(bus.sdram_read), 32'd0);
        ready_mode = 2;
        wait_done(n);

        ready_mode = 1;
        run(25'h1FFFFE5, 6);

        for (int i = 0; i < 5; i++) begin
            ready_mode = 2;
            ack_delay  = int'($urandom_range(0, 2));
            run(25'($urandom), int'($urandom_range(1, 20)));
        end

        ready_mode = 1; ack_delay = 0;
        n = done_cnt;
        issue(25'h0000040, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.sdram_read || busy) bad++;
        end
        check("zero_idle", 32'(bad), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'(n + 1));

        // reset in the middle of a burst
        issue(25'h0000400, 8);
        n = 0; t = 0;
        while (n < 2 && t < 200) begin
            @(negedge clk);
            if (bus.sdram_ack_100) n++;
            t++;
        end
        check("mid_ack_seen", 32'(n), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1; abort = 1'b1;
        exp_req.delete(); exp_pix.delete(); exp_done.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_read", 32'(bus.sdram_read), 32'd0);
        check("mid_rst_adrs", 32'(bus.sdram_adrs), 32'd0);
        check("mid_rst_burst", 32'(bus.sdram_burst), 32'd0);
        check("mid_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; abort = 1'b0;
        late_req++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.pix_valid || busy || bus.sdram_read || done) bad++;
        end
        check("late_ack_ignored", 32'(bad), 32'd0);

        ack_delay = 5; ready_mode = 1;
        run(25'h0000800, 8);
`ifdef SDRAM_LINE_READER_UNDERRUN_EN
        exp_under = (starve_cnt > 32'hFFFF) ? 16'hFFFF : 16'(starve_cnt);
`else
        exp_under = 16'd0;
`endif
        check("underrun", 32'(underrun), 32'(exp_under));
        ack_delay = 0;
        run(25'h0ABCDE8, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
